// File: rtl/lit_pkg.sv
// Shared LIT curve constants (breakpoints, slopes, offsets), forward arithmetic
// and the tonemapper state enum; both LIT directions take their numbers from here.
package lit_pkg;

  localparam int LT_IN    = 16;
  localparam int LT_OUT   = 9;
  localparam int LIT_SEGS = 10;

  // Index 0 describes segment 0 (c<<4) so lit_fwd covers every segment uniformly.
  localparam logic [8:0] LIT_B [LIT_SEGS] = '{
    9'h000, 9'h099, 9'h0A4, 9'h0B0, 9'h0BB, 9'h0C7, 9'h0D2, 9'h0DD, 9'h0E9, 9'h0F4
  };

  localparam logic [18:0] LIT_M [LIT_SEGS] = '{
    19'd4096,   19'd22323,  19'd33281,  19'd51200,  19'd76800,
    19'd115200, 19'd166400, 19'd204800, 19'd263424, 19'd467712
  };

  localparam logic [18:0] LIT_S [LIT_SEGS] = '{
    19'd0,      19'd11079,  19'd18099,  19'd30419,  19'd49119,
    19'd78969,  19'd120969, 19'd154119, 19'd207476, 19'd402187
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } lt_state_e;

  function automatic logic [15:0] lit_fwd(input logic [8:0] code, input logic [3:0] k);
    logic [31:0] prod;
    prod = 32'(code) * 32'(LIT_M[k]);
    return 16'((prod >> 8) - 32'(LIT_S[k]));
  endfunction

  // Segment k's threshold is its own line evaluated at its own breakpoint.
  function automatic logic [15:0] lit_thresh(input logic [3:0] k);
    return lit_fwd(LIT_B[k], k);
  endfunction

endpackage

// File: rtl/lit_div10.sv
// Restoring divider, 28-bit numerator by 19-bit divisor, 10-bit quotient.
// One quotient bit per cycle MSB first; done/quo are valid in the cycle of the last bit.
module lit_div10 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [27:0] num,
  input  logic [18:0] den,
  output logic        done,
  output logic [9:0]  quo
);

  logic [18:0] rem_reg, rem_next;
  logic [9:0]  low_reg, low_next;
  logic [18:0] den_reg, den_next;
  logic [9:0]  quo_reg, quo_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        busy_reg, busy_next;
  logic [19:0] trial;
  logic        fits;
  logic [9:0]  quo_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_reg  <= '0;
      low_reg  <= '0;
      den_reg  <= '0;
      quo_reg  <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
    end else begin
      rem_reg  <= rem_next;
      low_reg  <= low_next;
      den_reg  <= den_next;
      quo_reg  <= quo_next;
      cnt_reg  <= cnt_next;
      busy_reg <= busy_next;
    end
  end

  // The caller guarantees num < den<<10, so the top 18 bits start below den.
  always_comb begin
    trial     = {rem_reg, low_reg[9]};
    fits      = (trial >= {1'b0, den_reg});
    quo_step  = {quo_reg[8:0], fits};
    rem_next  = rem_reg;
    low_next  = low_reg;
    den_next  = den_reg;
    quo_next  = quo_reg;
    cnt_next  = cnt_reg;
    busy_next = busy_reg;
    if (start) begin
      rem_next  = {1'b0, num[27:10]};
      low_next  = num[9:0];
      den_next  = den;
      quo_next  = '0;
      cnt_next  = '0;
      busy_next = 1'b1;
    end else if (busy_reg) begin
      rem_next = fits ? 19'(trial - {1'b0, den_reg}) : trial[18:0];
      low_next = {low_reg[8:0], 1'b0};
      quo_next = quo_step;
      cnt_next = cnt_reg + 4'd1;
      if (cnt_reg == 4'd9) begin
        busy_next = 1'b0;
      end
    end
  end

  assign done = busy_reg && (cnt_reg == 4'd9);
  assign quo  = quo_step;

endmodule

// File: rtl/lit_tonemap.sv
// Forward linear tonemapper: maps a Q0.16 HDR sample back to the Q1.8 SDR code
// whose LIT expansion lands on or just below it, using an iterative divider.
module lit_tonemap
  import lit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LT_IN-1:0]  LT_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LT_OUT-1:0] LT_out
);

  lt_state_e         state_reg, state_next;
  logic [LT_IN-1:0]  sample_reg, sample_next;
  logic [3:0]        seg_reg, seg_next;
  logic [LT_OUT-1:0] lt_out_reg, lt_out_next;
  logic              out_valid_reg, out_valid_next;

  logic [LIT_SEGS-1:1] seg_ge;
  logic [3:0]          seg_sel;
  logic [LT_OUT-1:0]   seg0_code;
  logic [LT_OUT-1:0]   lo_code;
  logic [LT_OUT-1:0]   clamp_code;
  logic                div_start;
  logic [27:0]         div_num;
  logic [18:0]         div_den;
  logic                div_done;
  logic [9:0]          div_quo;

  genvar gi;
  generate
    for (gi = 1; gi < LIT_SEGS; gi++) begin : g_thr
      localparam logic [15:0] THR = lit_thresh(4'(gi));
      assign seg_ge[gi] = (sample_reg >= THR);
    end
  endgenerate

  // Ascending scan keeps the highest matching segment, so the overlap near B1 goes up.
  always_comb begin
    seg_sel = 4'd0;
    for (int k = 1; k < LIT_SEGS; k++) begin
      if (seg_ge[k]) begin
        seg_sel = 4'(k);
      end
    end
  end

  assign seg0_code = (sample_reg[15:4] > 12'h098) ? 9'h098 : sample_reg[12:4];
  assign div_num   = {1'b0, 19'({3'b000, sample_reg} + LIT_S[seg_sel]), 8'h00};
  assign div_den   = LIT_M[seg_sel];

  // The lower clamp absorbs truncation in the forward path at each breakpoint.
  always_comb begin
    lo_code = LIT_B[seg_reg];
    if (div_quo < {1'b0, lo_code}) begin
      clamp_code = lo_code;
    end else if (div_quo > 10'h100) begin
      clamp_code = 9'h100;
    end else begin
      clamp_code = div_quo[8:0];
    end
  end

  lit_div10 u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .num   (div_num),
    .den   (div_den),
    .done  (div_done),
    .quo   (div_quo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      sample_reg    <= '0;
      seg_reg       <= '0;
      lt_out_reg    <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sample_reg    <= sample_next;
      seg_reg       <= seg_next;
      lt_out_reg    <= lt_out_next;
      out_valid_reg <= out_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    sample_next    = sample_reg;
    seg_next       = seg_reg;
    lt_out_next    = lt_out_reg;
    out_valid_next = out_valid_reg;
    div_start      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          sample_next = LT_in;
          state_next  = ST_SEL;
        end
      end
      ST_SEL: begin
        seg_next = seg_sel;
        if (seg_sel == 4'd0) begin
          lt_out_next    = seg0_code;
          out_valid_next = 1'b1;
          state_next     = ST_DONE;
        end else begin
          div_start  = 1'b1;
          state_next = ST_DIV;
        end
      end
      ST_DIV: begin
        if (div_done) begin
          lt_out_next    = clamp_code;
          out_valid_next = 1'b1;
          state_next     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = out_valid_reg;
  assign LT_out    = lt_out_reg;

endmodule
